// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage core. It merges the stage stall requests
// into one hold vector. It turns MEM-stage exceptions into a single-cycle flush
// plus a redirect PC, and it masks the following cycle. It also keeps a stall
// watchdog and performance counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | normal operation; a nonzero excepttype_i triggers a flush
// RECOVER | one cycle after a flush; a stale exception code is ignored
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE   = 32'h0000000E,
    parameter int          WDOG_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        wdog_timeout
);

    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] wdog_cnt_q;
    logic        wdog_timeout_q;
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;
    logic [5:0]  stall_req;

    // Priority merge of stall requests: the deepest requesting stage wins,
    // and the stage just after it sees a bubble.
    always_comb begin
        if (stallreq_mem)      stall_req = 6'b011111;
        else if (stallreq_ex)  stall_req = 6'b001111;
        else if (stallreq_id)  stall_req = 6'b000111;
        else if (stallreq_if)  stall_req = 6'b000011;
        else                   stall_req = 6'b000000;
    end

    // Next state plus the same-cycle outputs; reset holds everything quiet.
    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        new_pc  = 32'h0;
        stall   = 6'b000000;
        if (resetn) begin
            case (state_q)
                IDLE: begin
                    if (excepttype_i != 32'h0) begin
                        flush   = 1'b1;
                        new_pc  = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                        state_d = RECOVER;
                    end
                end
                RECOVER: state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (!flush) begin
                stall = stall_req;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Performance counters and stall watchdog.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cycles_q <= 32'h0;
            flush_count_q  <= 16'h0;
            wdog_cnt_q     <= 16'h0;
            wdog_timeout_q <= 1'b0;
        end else begin
            if (stall != 6'b000000) begin
                stall_cycles_q <= stall_cycles_q + 32'h1;
            end
            if (flush && (flush_count_q != 16'hFFFF)) begin
                flush_count_q <= flush_count_q + 16'h1;
            end
            if (stall[0]) begin
                if (wdog_cnt_q >= WDOG_LAST) begin
                    wdog_timeout_q <= 1'b1;
                end else begin
                    wdog_cnt_q <= wdog_cnt_q + 16'h1;
                end
            end else begin
                wdog_cnt_q <= 16'h0;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign wdog_timeout = wdog_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC00380;
    localparam logic [31:0] ERET = 32'h0000000E;
    localparam int          WDOG = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic        wdog_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_prev_flush;
    int          m_run;
    bit          m_timeout;
    logic [31:0] m_stall_cycles;
    int          m_flush_count;

    // expectations and observations for the cycle just ended
    logic [5:0]  e_stall, o_stall;
    logic        e_flush, o_flush;
    logic [31:0] e_pc, o_pc;

    always #5 clk = ~clk;

    pipeline_ctrl #(.EXC_VECTOR(VEC), .ERET_CODE(ERET), .WDOG_CYCLES(WDOG)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .wdog_timeout (wdog_timeout)
    );

    // One clock cycle: sample the combinational outputs mid-cycle, derive the
    // model's expectation, then advance the model across the rising edge.
    task automatic tick();
        int held;
        @(negedge clk);
        o_stall = stall;
        o_flush = flush;
        o_pc    = new_pc;
        e_stall = 6'b0;
        e_flush = 1'b0;
        e_pc    = 32'h0;
        if (resetn) begin
            e_flush = (excepttype_i != 0) && !m_prev_flush;
            if (e_flush) begin
                e_pc = (excepttype_i == ERET) ? cp0_epc_i : VEC;
            end else begin
                held = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
                e_stall = 6'((1 << held) - 1);
            end
        end
        @(posedge clk);
        if (!resetn) begin
            m_prev_flush   = 0;
            m_run          = 0;
            m_timeout      = 0;
            m_stall_cycles = 0;
            m_flush_count  = 0;
        end else begin
            m_prev_flush = e_flush;
            if (e_stall != 0) m_stall_cycles = m_stall_cycles + 1;
            if (e_flush && m_flush_count < 65535) m_flush_count++;
            m_run = e_stall[0] ? m_run + 1 : 0;
            if (m_run >= WDOG) m_timeout = 1;
        end
        #1;
    endtask

    task automatic set_reqs(input bit i_if, input bit i_id, input bit i_ex, input bit i_mem);
        stallreq_if  = i_if;
        stallreq_id  = i_id;
        stallreq_ex  = i_ex;
        stallreq_mem = i_mem;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_reqs(0, 0, 0, 0);
        excepttype_i = 0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_reqs(1, 1, 1, 1);
        excepttype_i = 32'h1;
        cp0_epc_i    = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (o_stall !== 6'b0 || o_flush !== 1'b0 || o_pc !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_comb cyc%0d: stall=%b flush=%b new_pc=%h, required 0/0/0", i, o_stall, o_flush, o_pc);
            end
        end
        resetn = 1'b1;
        set_reqs(0, 0, 0, 0);
        excepttype_i = 0;
        n_checks++;
        if (stall_cycles !== 0 || flush_count !== 0 || wdog_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_regs: stall_cycles=%0d flush_count=%0d wdog=%b, required 0/0/0", stall_cycles, flush_count, wdog_timeout);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_reqs(0, 1, 0, 1);
        tick();
        n_checks++;
        if (o_stall !== 6'b011111) begin
            n_errors++;
            $display("FAIL prio_mem_id: stall=%b, required 011111", o_stall);
        end
        set_reqs(0, 1, 0, 0);
        tick();
        n_checks++;
        if (o_stall !== 6'b000111) begin
            n_errors++;
            $display("FAIL prio_id: stall=%b, required 000111", o_stall);
        end
        set_reqs(0, 0, 0, 0);
        tick();
        n_checks++;
        if (o_stall !== 6'b000000) begin
            n_errors++;
            $display("FAIL prio_none: stall=%b, required 000000", o_stall);
        end
        n_checks++;
        if (stall_cycles !== 32'd2) begin
            n_errors++;
            $display("FAIL prio_stall_cycles: got %0d, required 2", stall_cycles);
        end
        set_reqs(0, 0, 1, 0);
        tick();
        n_checks++;
        if (o_stall !== 6'b001111) begin
            n_errors++;
            $display("FAIL prio_ex: stall=%b, required 001111", o_stall);
        end
        set_reqs(1, 0, 0, 0);
        tick();
        n_checks++;
        if (o_stall !== 6'b000011) begin
            n_errors++;
            $display("FAIL prio_if: stall=%b, required 000011", o_stall);
        end
        set_reqs(0, 0, 0, 0);
    endtask

    task automatic test_exception();
        do_reset();
        set_reqs(0, 0, 1, 0);
        excepttype_i = 32'h0000000C;
        cp0_epc_i    = 32'h80000010;
        tick();
        n_checks++;
        if (o_flush !== 1'b1 || o_stall !== 6'b0 || o_pc !== VEC) begin
            n_errors++;
            $display("FAIL exc_flush: flush=%b stall=%b new_pc=%h, required 1/000000/%h", o_flush, o_stall, o_pc, VEC);
        end
        n_checks++;
        if (flush_count !== 16'd1) begin
            n_errors++;
            $display("FAIL exc_flush_count: got %0d, required 1", flush_count);
        end
        excepttype_i = 0;
        tick();
        n_checks++;
        if (o_flush !== 1'b0 || o_stall !== 6'b001111) begin
            n_errors++;
            $display("FAIL exc_after: flush=%b stall=%b, required 0/001111", o_flush, o_stall);
        end
        set_reqs(0, 0, 0, 0);
    endtask

    task automatic test_eret();
        do_reset();
        excepttype_i = ERET;
        cp0_epc_i    = 32'h80001234;
        tick();
        n_checks++;
        if (o_flush !== 1'b1 || o_pc !== 32'h80001234) begin
            n_errors++;
            $display("FAIL eret_first: flush=%b new_pc=%h, required 1/80001234", o_flush, o_pc);
        end
        tick();
        n_checks++;
        if (o_flush !== 1'b0) begin
            n_errors++;
            $display("FAIL eret_masked: flush=%b, required 0", o_flush);
        end
        n_checks++;
        if (flush_count !== 16'd1) begin
            n_errors++;
            $display("FAIL eret_flush_count: got %0d, required 1", flush_count);
        end
        excepttype_i = 0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] seen;
        do_reset();
        excepttype_i = 32'h00000004;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen[i] = o_flush;
        end
        excepttype_i = 0;
        n_checks++;
        if (seen !== 3'b101) begin
            n_errors++;
            $display("FAIL b2b_pattern: flush cycles 2..0=%b, required 101", seen);
        end
        n_checks++;
        if (flush_count !== 16'd2) begin
            n_errors++;
            $display("FAIL b2b_flush_count: got %0d, required 2", flush_count);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        set_reqs(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (wdog_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL wdog_7: wdog_timeout=%b, required 0", wdog_timeout);
        end
        tick();
        n_checks++;
        if (wdog_timeout !== 1'b1) begin
            n_errors++;
            $display("FAIL wdog_8: wdog_timeout=%b, required 1", wdog_timeout);
        end
        set_reqs(0, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if (wdog_timeout !== 1'b1 || o_stall !== 6'b0) begin
            n_errors++;
            $display("FAIL wdog_sticky: wdog_timeout=%b stall=%b, required 1/000000", wdog_timeout, o_stall);
        end
        do_reset();
        set_reqs(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        set_reqs(0, 0, 0, 0);
        tick();
        set_reqs(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        set_reqs(0, 0, 0, 0);
        n_checks++;
        if (wdog_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL wdog_gap: wdog_timeout=%b, required 0", wdog_timeout);
        end
        // a flush cycle must also restart the stall run
        do_reset();
        set_reqs(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        excepttype_i = 32'h8;
        tick();
        excepttype_i = 0;
        for (int i = 0; i < 5; i++) tick();
        set_reqs(0, 0, 0, 0);
        n_checks++;
        if (wdog_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL wdog_flush_gap: wdog_timeout=%b, required 0", wdog_timeout);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 49) != 0);
            set_reqs($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
            r = $urandom_range(0, 9);
            if (r < 6)       excepttype_i = 0;
            else if (r < 8)  excepttype_i = ERET;
            else             excepttype_i = $urandom | 32'h1;
            cp0_epc_i = $urandom;
            tick();
            n_checks++;
            if (o_stall !== e_stall || o_flush !== e_flush) begin
                n_errors++;
                $display("FAIL rand_comb cyc%0d: stall=%b flush=%b, required %b/%b", i, o_stall, o_flush, e_stall, e_flush);
            end
            if (e_flush || !resetn) begin
                n_checks++;
                if (o_pc !== e_pc) begin
                    n_errors++;
                    $display("FAIL rand_pc cyc%0d: new_pc=%h, required %h", i, o_pc, e_pc);
                end
            end
            n_checks++;
            if (stall_cycles !== m_stall_cycles || flush_count !== 16'(m_flush_count) || wdog_timeout !== m_timeout) begin
                n_errors++;
                $display("FAIL rand_regs cyc%0d: stall_cycles=%0d flush_count=%0d wdog=%b, required %0d/%0d/%b",
                         i, stall_cycles, flush_count, wdog_timeout, m_stall_cycles, m_flush_count, m_timeout);
            end
        end
        resetn = 1'b1;
    endtask

    initial begin
        m_prev_flush   = 0;
        m_run          = 0;
        m_timeout      = 0;
        m_stall_cycles = 0;
        m_flush_count  = 0;
        resetn         = 1'b0;
        set_reqs(0, 0, 0, 0);
        excepttype_i   = 0;
        cp0_epc_i      = 0;
        test_reset();
        test_priority();
        test_exception();
        test_eret();
        test_back_to_back();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
